// File: rtl/apb_cmd_master_if.sv
// APB3 bus bundle shared by the command master (src) and the register slaves (sink).
interface apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport src (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport sink (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: valid/ready command in, valid/ready response out,
// with a bounded ACCESS phase and local error responses for unaligned or timed-out accesses.
module apb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hBADD_C0DE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    apb_if.src          apbReg,
    output logic [7:0]  timeout_cnt
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic             write_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic             err_reg;
    logic             timeout_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [7:0]       timeout_cnt_reg;

    logic             unaligned;
    logic             timeout_hit;

    assign unaligned = (req_addr[1:0] != 2'b00);

    // pready wins over a coinciding expiry because timeout_hit requires pready low
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_reg == TIMEOUT_LAST)
                         && !apbReg.pready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = unaligned ? RESP : SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (apbReg.pready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and bus-phase strobes are pure state decodes, so reset removes them at once
    always_comb begin
        req_ready      = (state_reg == IDLE);
        rsp_valid      = (state_reg == RESP);
        apbReg.psel    = (state_reg == SETUP) || (state_reg == ACCESS);
        apbReg.penable = (state_reg == ACCESS);
        apbReg.pwrite  = write_reg;
        apbReg.paddr   = addr_reg;
        apbReg.pwdata  = wdata_reg;
        rsp_rdata      = rdata_reg;
        rsp_err        = err_reg;
        rsp_timeout    = timeout_reg;
        timeout_cnt    = timeout_cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg       <= 1'b0;
            addr_reg        <= 32'h0;
            wdata_reg       <= 32'h0;
            rdata_reg       <= 32'h0;
            err_reg         <= 1'b0;
            timeout_reg     <= 1'b0;
            wait_cnt_reg    <= '0;
            timeout_cnt_reg <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        if (unaligned) begin
                            rdata_reg   <= ERR_DATA;
                            err_reg     <= 1'b1;
                            timeout_reg <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    wait_cnt_reg <= '0;
                end
                ACCESS: begin
                    if (apbReg.pready) begin
                        rdata_reg   <= write_reg ? 32'h0 : apbReg.prdata;
                        err_reg     <= apbReg.pslverr;
                        timeout_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_reg   <= ERR_DATA;
                        err_reg     <= 1'b1;
                        timeout_reg <= 1'b1;
                        if (timeout_cnt_reg != 8'hFF) begin
                            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed plus randomized checks of apb_cmd_master against a behavioural transaction model
// and a simple wait-state APB slave.
module tb_apb_cmd_master;

    localparam int unsigned T   = 4;
    localparam logic [31:0] ERR = 32'hBADD_C0DE;
    localparam logic [31:0] SLV_ERR_ADDR = 32'h0000_003C;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [7:0]  timeout_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_if bus ();

    apb_cmd_master #(
        .TIMEOUT_CYCLES(T),
        .ERR_DATA      (ERR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .apbReg     (bus),
        .timeout_cnt(timeout_cnt)
    );

    // Slave: pready after slave_waits wait states, pslverr at one fixed address
    int unsigned slave_waits = 0;
    int unsigned acc_cnt = 0;
    logic [31:0] slave_mem [64] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
            slave_mem[bus.paddr[7:2]] <= bus.pwdata;
    end

    assign bus.pready  = bus.psel && bus.penable && (acc_cnt == slave_waits);
    assign bus.pslverr = bus.pready && (bus.paddr == SLV_ERR_ADDR);
    assign bus.prdata  = (bus.paddr == SLV_ERR_ADDR) ? 32'hBADD_C0DE : slave_mem[bus.paddr[7:2]];

    // Reference model state
    logic [31:0] model_mem [64] = '{default: 32'h0};
    int          model_tcnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned waits, input int hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
        int          exp_pen;
        int          exp_psel;
        int          lat;
        int          pen;
        int          psel_cnt;
        logic        addr_ok;
        logic        stable_ok;
        logic [5:0]  idx;
        idx = addr[7:2];
        if (addr[1:0] != 2'b00) begin
            exp_err = 1'b1; exp_to = 1'b0; exp_rdata = ERR; exp_lat = 1; exp_pen = 0; exp_psel = 0;
        end else if (waits >= T) begin
            exp_err = 1'b1; exp_to = 1'b1; exp_rdata = ERR;
            exp_pen = T; exp_psel = T + 1; exp_lat = 2 + T;
            if (model_tcnt < 255) model_tcnt++;
        end else begin
            exp_to   = 1'b0;
            exp_err  = (addr == SLV_ERR_ADDR);
            exp_pen  = waits + 1;
            exp_psel = waits + 2;
            exp_lat  = 3 + waits;
            if (wr) begin
                exp_rdata = 32'h0;
                if (!exp_err) model_mem[idx] = wdata;
            end else begin
                exp_rdata = exp_err ? 32'hBADD_C0DE : model_mem[idx];
            end
        end

        @(negedge clk);
        slave_waits = waits;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; pen = 0; psel_cnt = 0; addr_ok = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (bus.psel) begin
                psel_cnt++;
                if (bus.paddr !== addr || bus.pwrite !== wr || (wr && bus.pwdata !== wdata))
                    addr_ok = 1'b0;
            end
            if (bus.penable) pen++;
            @(negedge clk);
            lat++;
        end
        $display("txn wr=%0d addr=%h wdata=%h waits=%0d lat=%0d rdata=%h err=%0d to=%0d",
                 wr, addr, wdata, waits, lat, rsp_rdata, rsp_err, rsp_timeout);
        check("rsp_latency", lat, exp_lat);
        check("penable_cycles", pen, exp_pen);
        check("psel_cycles", psel_cnt, exp_psel);
        check("apb_addr_data", {31'b0, addr_ok}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);

        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== exp_rdata ||
                rsp_err !== exp_err || rsp_timeout !== exp_to || bus.psel !== 1'b0)
                stable_ok = 1'b0;
        end
        check("rsp_hold_stable", {31'b0, stable_ok}, 32'd1);

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_back", {31'b0, req_ready}, 32'd1);
        check("timeout_cnt", {24'b0, timeout_cnt}, model_tcnt);
    endtask

    initial begin
        logic        seen;
        logic        rand_wr;
        logic [31:0] rand_addr;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_psel", {31'b0, bus.psel}, 32'd0);
        check("reset_penable", {31'b0, bus.penable}, 32'd0);
        check("reset_paddr", bus.paddr, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_timeout_cnt", {24'b0, timeout_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_txn(1'b1, 32'h0000_00A8, 32'h0000_0055, 0, 0);
        run_txn(1'b0, 32'h0000_00A8, 32'h0, 0, 0);
        run_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 0, 0);
        run_txn(1'b0, 32'h0000_0004, 32'h0, 2, 0);
        run_txn(1'b0, 32'h0000_003C, 32'h0, 0, 0);
        run_txn(1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 0, 0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 255, 0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 3, 0);
        run_txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 10);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 0, 10);

        for (int n = 0; n < 30; n++) begin
            rand_wr   = 1'($urandom_range(0, 1));
            rand_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 7) == 0) rand_addr[1:0] = 2'($urandom_range(1, 3));
            run_txn(rand_wr, rand_addr, $urandom, $urandom_range(0, 5), $urandom_range(0, 3));
        end

        // Reset while in ACCESS: strobes drop immediately, nothing comes back
        @(negedge clk);
        slave_waits = 10;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0008;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.penable) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_reached_access", {31'b0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_psel_drop", {31'b0, bus.psel}, 32'd0);
        check("rst_penable_drop", {31'b0, bus.penable}, 32'd0);
        check("rst_timeout_cnt", {24'b0, timeout_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_tcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || bus.psel) seen = 1'b1;
        end
        $display("reset during access: later response or bus activity=%0d", seen);
        check("rst_no_response", {31'b0, seen}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);

        run_txn(1'b0, 32'h0000_00A8, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
